pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 64 ++++++
 rtl/pipe_slot.sv | 53 +++++
 rtl/pipe_stage_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers:
// control-bundle layout and skid-buffer state encoding.
package pipe_pkg;

  localparam int W_ALUOP     = 4;
  localparam int W_ALUSRCA   = 2;
  localparam int W_ALUSRCB   = 1;
  localparam int W_DMEM_BE   = 4;
  localparam int W_DMEM_WEN  = 1;
  localparam int W_MEMREAD   = 1;
  localparam int W_PCSRC     = 2;
  localparam int W_ISJUMP    = 1;
  localparam int W_ISLOAD    = 1;
  localparam int W_RWSRC     = 2;
  localparam int W_OPSRC     = 2;
  localparam int W_RF_WE     = 1;
  localparam int W_NUM_CHECK = 1;
  localparam int W_HALT      = 1;

  localparam int OFF_ALUOP     = 0;
  localparam int OFF_ALUSRCA   = OFF_ALUOP     + W_ALUOP;
  localparam int OFF_ALUSRCB   = OFF_ALUSRCA   + W_ALUSRCA;
  localparam int OFF_DMEM_BE   = OFF_ALUSRCB   + W_ALUSRCB;
  localparam int OFF_DMEM_WEN  = OFF_DMEM_BE   + W_DMEM_BE;
  localparam int OFF_MEMREAD   = OFF_DMEM_WEN  + W_DMEM_WEN;
  localparam int OFF_PCSRC     = OFF_MEMREAD   + W_MEMREAD;
  localparam int OFF_ISJUMP    = OFF_PCSRC     + W_PCSRC;
  localparam int OFF_ISLOAD    = OFF_ISJUMP    + W_ISJUMP;
  localparam int OFF_RWSRC     = OFF_ISLOAD    + W_ISLOAD;
  localparam int OFF_OPSRC     = OFF_RWSRC     + W_RWSRC;
  localparam int OFF_RF_WE     = OFF_OPSRC     + W_OPSRC;
  localparam int OFF_NUM_CHECK = OFF_RF_WE     + W_RF_WE;
  localparam int OFF_HALT      = OFF_NUM_CHECK + W_NUM_CHECK;

  localparam int CTRL_BUNDLE_W = OFF_HALT + W_HALT;

  typedef struct packed {
    logic [W_HALT-1:0]      halt;
    logic [W_NUM_CHECK-1:0] num_check;
    logic [W_RF_WE-1:0]     rf_we;
    logic [W_OPSRC-1:0]     op_src;
    logic [W_RWSRC-1:0]     rw_src;
    logic [W_ISLOAD-1:0]    is_load;
    logic [W_ISJUMP-1:0]    is_jump;
    logic [W_PCSRC-1:0]     pc_src;
    logic [W_MEMREAD-1:0]   mem_read;
    logic [W_DMEM_WEN-1:0]  d_mem_wen;
    logic [W_DMEM_BE-1:0]   d_mem_be;
    logic [W_ALUSRCB-1:0]   alu_src_b;
    logic [W_ALUSRCA-1:0]   alu_src_a;
    logic [W_ALUOP-1:0]     alu_op;
  } ctrl_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_TWO   = TWO
  } skid_st_e;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data+ctrl register with clear/load/hold.
// Control is masked by valid so an empty slot never drives controls.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 24
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              v,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              v_d, v_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  // clear keeps the payload; only valid and control are dropped
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (clr) begin
      v_d    = 1'b0;
      ctrl_d = '0;
    end else if (ld) begin
      v_d    = 1'b1;
      data_d = d_data;
      ctrl_d = d_ctrl;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      v_q    <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign v    = v_q;
  assign data = data_q;
  assign ctrl = ctrl_q & {CTRL_W{v_q}};

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake,
// stall/flush, optional skid buffer and perf counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = CTRL_BUNDLE_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              main_ld, main_clr;
  logic              main_from_skid;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic              accept, issue;

  assign accept = in_valid & in_ready;
  assign issue  = main_v & out_ready & ~stall;

  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .ld     (main_ld),
    .clr    (main_clr),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .v      (main_v),
    .data   (main_data),
    .ctrl   (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      skid_st_e st_q, st_d;
      logic     skid_ld, skid_clr;

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .ld     (skid_ld),
        .clr    (skid_clr),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .v      (skid_v),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
      );

      always_ff @(posedge CLK) begin
        if (!RSTn) st_q <= ST_EMPTY;
        else       st_q <= st_d;
      end

      // flush beats stall; stall freezes everything
      always_comb begin
        st_d           = st_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
          st_d     = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end else if (!stall) begin
          case (st_q)
            ST_EMPTY: begin
              if (accept) begin
                main_ld = 1'b1;
                st_d    = ST_ONE;
              end
            end
            ST_ONE: begin
              if (accept && issue) begin
                main_ld = 1'b1;
              end else if (accept) begin
                skid_ld = 1'b1;
                st_d    = ST_TWO;
              end else if (issue) begin
                main_clr = 1'b1;
                st_d     = ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (issue) begin
                main_ld        = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
                st_d           = ST_ONE;
              end
            end
            default: begin
              main_clr = 1'b1;
              skid_clr = 1'b1;
              st_d     = ST_EMPTY;
            end
          endcase
        end
      end

      // ready depends only on flops plus stall, never on out_ready
      assign in_ready = RSTn & ~skid_v & ~stall;
    end else begin : g_noskid
      assign skid_v         = 1'b0;
      assign skid_data      = '0;
      assign skid_ctrl      = '0;
      assign main_from_skid = 1'b0;

      always_comb begin
        main_ld  = 1'b0;
        main_clr = 1'b0;
        if (flush)       main_clr = 1'b1;
        else if (accept) main_ld  = 1'b1;
        else if (issue)  main_clr = 1'b1;
      end

      assign in_ready = RSTn & ~stall & (~main_v | out_ready);
    end
  endgenerate

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && main_v && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cnt = stall_cnt_q;

  logic unused_skid_ctrl_ok;
  assign unused_skid_ctrl_ok = 1'b0;

endmodule
